// File: rtl/dma_pkg.sv
// DMA shared types: descriptors, error reports, AXI burst requests
// and the stream FSM states.
package dma_pkg;

  localparam int DMA_ADDR_W      = 32;
  localparam int DMA_BYTES_W     = 32;
  localparam int DMA_4K_BOUNDARY = 4096;

  // AXI AxBURST encoding
  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01
  } dma_burst_t;

  typedef enum logic [1:0] {
    DMA_ERR_SRC_NONE      = 2'd0,
    DMA_ERR_SRC_STREAM_RD = 2'd1,
    DMA_ERR_SRC_STREAM_WR = 2'd2
  } dma_err_src_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ERR,
    ST_DONE,
    ST_WAIT
  } dma_stream_st_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0]  src_addr;
    logic [DMA_ADDR_W-1:0]  dst_addr;
    logic [DMA_BYTES_W-1:0] num_bytes;
    dma_burst_t             rd_mode;
    dma_burst_t             wr_mode;
  } s_dma_desc_t;

  typedef struct packed {
    logic                  valid;
    dma_err_src_t          src;
    logic [DMA_ADDR_W-1:0] addr;
  } s_dma_error_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [7:0]            alen;
    logic [2:0]            size;
    dma_burst_t            burst;
  } s_dma_axi_req_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: clips the remaining transfer to the
// 4 KB page and the maximum burst length.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BYTES_WIDTH     = 32,
  parameter int MAX_BURST_BEATS = 256
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [BYTES_WIDTH-1:0] bytes_rem,
  input  dma_burst_t             mode,
  output logic [8:0]             beats,
  output logic [7:0]             alen,
  output logic [2:0]             size,
  output dma_burst_t             burst
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [BYTES_WIDTH-1:0] MAXB = BYTES_WIDTH'(MAX_BURST_BEATS);

  logic [11:0]            addr_lo;
  logic [12:0]            span;
  logic [BYTES_WIDTH-1:0] rem_beats;
  logic [BYTES_WIDTH-1:0] lim;
  logic [BYTES_WIDTH-1:0] cap;
  logic [BYTES_WIDTH-1:0] bw;

  always_comb begin
    addr_lo   = 12'(addr);
    span      = 13'(DMA_4K_BOUNDARY) - {1'b0, addr_lo};
    rem_beats = bytes_rem >> OFF;
    lim       = (mode == FIXED) ? MAXB
                                : BYTES_WIDTH'(span >> OFF);
    cap       = (lim < MAXB) ? lim : MAXB;
    bw        = (rem_beats < cap) ? rem_beats : cap;
    beats     = 9'(bw);
    alen      = 8'(beats - 9'd1);
    size      = 3'(OFF);
    burst     = mode;
  end

endmodule

// File: rtl/dma_streamer.sv
// One side of a DMA descriptor: splits the byte count into AXI
// burst requests and reports done/error to the control FSM.
module dma_streamer
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BYTES_WIDTH     = 32,
  parameter int MAX_BURST_BEATS = 256,
  parameter int STREAM_TYPE     = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  s_dma_desc_t    dma_desc_i,
  input  logic           dma_stream_valid_i,
  output logic           dma_stream_done_o,
  output s_dma_error_t   dma_stream_err_o,
  output s_dma_axi_req_t dma_axi_req_o,
  output logic           dma_axi_req_valid_o,
  input  logic           dma_axi_req_ready_i
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int BPB = DATA_WIDTH / 8;

  dma_stream_st_t         st_q, st_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BYTES_WIDTH-1:0] rem_q;
  dma_burst_t             mode_q;

  logic [ADDR_WIDTH-1:0]  desc_addr;
  logic [BYTES_WIDTH-1:0] desc_bytes;
  dma_burst_t             desc_mode;
  logic                   misalign;
  logic                   hs;
  logic [BYTES_WIDTH-1:0] rem_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;

  logic [8:0]             beats;
  logic [7:0]             alen;
  logic [2:0]             size;
  dma_burst_t             burst;

  dma_burst_calc #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .BYTES_WIDTH     (BYTES_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_calc (
    .addr      (addr_q),
    .bytes_rem (rem_q),
    .mode      (mode_q),
    .beats     (beats),
    .alen      (alen),
    .size      (size),
    .burst     (burst)
  );

  always_comb begin
    desc_addr  = (STREAM_TYPE != 0)
               ? ADDR_WIDTH'(dma_desc_i.dst_addr)
               : ADDR_WIDTH'(dma_desc_i.src_addr);
    desc_mode  = (STREAM_TYPE != 0) ? dma_desc_i.wr_mode
                                    : dma_desc_i.rd_mode;
    desc_bytes = BYTES_WIDTH'(dma_desc_i.num_bytes);
    misalign   = ((desc_addr & ADDR_WIDTH'(BPB - 1)) != '0) ||
                 ((desc_bytes & BYTES_WIDTH'(BPB - 1)) != '0);
    hs         = (st_q == ST_REQ) && dma_axi_req_ready_i;
    rem_nxt    = rem_q - (BYTES_WIDTH'(beats) << OFF);
    addr_nxt   = (mode_q == FIXED) ? addr_q
               : addr_q + (ADDR_WIDTH'(beats) << OFF);
  end

  always_comb begin
    st_d                = st_q;
    dma_axi_req_valid_o = 1'b0;
    dma_axi_req_o       = '0;
    dma_stream_done_o   = 1'b0;
    dma_stream_err_o    = '0;
    unique case (st_q)
      ST_IDLE: begin
        if (dma_stream_valid_i) begin
          if (desc_bytes == '0)
            st_d = ST_DONE;
          else if (misalign)
            st_d = ST_ERR;
          else
            st_d = ST_REQ;
        end
      end
      ST_REQ: begin
        dma_axi_req_valid_o = 1'b1;
        dma_axi_req_o.addr  = DMA_ADDR_W'(addr_q);
        dma_axi_req_o.alen  = alen;
        dma_axi_req_o.size  = size;
        dma_axi_req_o.burst = burst;
        // an abort only takes effect once the pending burst is accepted
        if (hs) begin
          if (!dma_stream_valid_i)
            st_d = ST_IDLE;
          else if (rem_nxt == '0)
            st_d = ST_DONE;
        end
      end
      ST_ERR: begin
        dma_stream_err_o.valid = 1'b1;
        dma_stream_err_o.src   = (STREAM_TYPE != 0)
                               ? DMA_ERR_SRC_STREAM_WR
                               : DMA_ERR_SRC_STREAM_RD;
        dma_stream_err_o.addr  = DMA_ADDR_W'(addr_q);
        st_d                   = ST_DONE;
      end
      ST_DONE: begin
        dma_stream_done_o = 1'b1;
        st_d              = ST_WAIT;
      end
      ST_WAIT: begin
        if (!dma_stream_valid_i)
          st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= ST_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      mode_q <= FIXED;
    end else begin
      st_q <= st_d;
      if (st_q == ST_IDLE && dma_stream_valid_i) begin
        addr_q <= desc_addr;
        rem_q  <= desc_bytes;
        mode_q <= desc_mode;
      end else if (hs) begin
        addr_q <= addr_nxt;
        rem_q  <= rem_nxt;
      end
    end
  end

endmodule

// File: doc/dma_streamer.md
Name: dma_streamer

Overview:
- Executes one side of a DMA descriptor on behalf of the DMA control FSM.
- One instance serves the read side and one serves the write side, selected by STREAM_TYPE.
- Accepts the FSM's stream-valid request and splits the descriptor's byte count into AXI INCR/FIXED burst requests for the AXI interface. Bursts never cross a 4 KB boundary or exceed the maximum burst length.
- Returns a single-cycle done pulse and a single-cycle error report to the FSM.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI data bus width in bits; BPB = DATA_WIDTH/8 bytes per beat (power of 2).
- BYTES_WIDTH, 32, width of descriptor num_bytes.
- MAX_BURST_BEATS, 256, maximum beats per burst (1..256).
- STREAM_TYPE, 0, 0 = read streamer (uses src_addr/rd_mode), 1 = write streamer (uses dst_addr/wr_mode).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- dma_desc_i  in  s_dma_desc_t  descriptor (src_addr, dst_addr, num_bytes, rd_mode, wr_mode); stable while valid.
- dma_stream_valid_i  in  1  FSM request to execute the descriptor.
- dma_stream_done_o  out  1  one-cycle pulse: descriptor finished (normal or after error).
- dma_stream_err_o  out  s_dma_error_t  {valid, src, addr}; valid pulses one cycle.
- dma_axi_req_o  out  s_dma_axi_req_t  {addr, alen, size, burst}.
- dma_axi_req_valid_o  out  1  burst request valid.
- dma_axi_req_ready_i  in  1  AXI I/F accepts request.

Behaviour:
- All outputs are 0 during reset, and reset is asynchronous: asserting rstn low forces IDLE and drops dma_axi_req_valid_o immediately, even mid-burst.
- State machine: ST_IDLE, ST_REQ, ST_ERR, ST_DONE, ST_WAIT.
- ST_IDLE, when dma_stream_valid_i = 1, latches the following:
  - addr_ff = STREAM_TYPE ? dst_addr : src_addr
  - bytes_rem_ff = num_bytes
  - mode_ff = the matching rd_mode or wr_mode
- Transition out of ST_IDLE, in priority order:
  - num_bytes == 0 -> ST_DONE, with no request issued.
  - addr[log2(BPB)-1:0] != 0 or num_bytes[log2(BPB)-1:0] != 0 -> ST_ERR.
  - Otherwise -> ST_REQ.
- Burst calculation, combinational from the registers:
  - rem_beats = bytes_rem_ff >> log2(BPB)
  - beats_4k = (4096 - addr_ff[11:0]) >> log2(BPB); in FIXED mode beats_4k = MAX_BURST_BEATS
  - beats = min(rem_beats, beats_4k, MAX_BURST_BEATS)
  - alen = beats - 1
  - size = log2(BPB)
  - burst = INCR, or FIXED when mode_ff = FIXED
- ST_REQ:
  - dma_axi_req_valid_o = 1, with dma_axi_req_o fully driven from registers.
  - valid is first asserted the cycle after ST_IDLE samples dma_stream_valid_i.
  - Request fields are held stable while ready = 0 (AXI rule: valid is never withdrawn before the handshake).
- On the ST_REQ handshake (valid & ready):
  - bytes_rem_ff -= beats*BPB.
  - addr_ff += beats*BPB in INCR mode; unchanged in FIXED mode.
  - If the new bytes_rem = 0 -> ST_DONE; else stay in ST_REQ. Back-to-back bursts are allowed, so valid stays high the next cycle.
- ST_ERR, lasting one cycle:
  - dma_err_o.valid = 1.
  - src = STREAM_TYPE ? DMA_ERR_SRC_STREAM_WR : DMA_ERR_SRC_STREAM_RD.
  - addr = latched addr_ff.
  - Next state -> ST_DONE. No AXI request is ever issued for a rejected descriptor.
- ST_DONE, lasting one cycle: dma_stream_done_o = 1, then -> ST_WAIT.
- ST_WAIT: stays until dma_stream_valid_i = 0, then -> ST_IDLE. This prevents re-triggering while the FSM is still latching done.
- Abort: if dma_stream_valid_i falls in ST_REQ:
  - a request already presented completes its handshake first;
  - then the block goes -> ST_IDLE with no done pulse and no further requests.
- Arithmetic and widths:
  - beats is 9 bits; bytes_rem_ff is BYTES_WIDTH bits.
  - addr_ff wraps modulo 2^ADDR_WIDTH; wrap is not flagged.
- Back-to-back descriptors: a new valid is seen only after ST_WAIT has returned to ST_IDLE.

Decomposition:
- Additions to dma_pkg:
  - s_dma_axi_req_t
  - dma_stream_st_t (the five states)
  - DMA_4K_BOUNDARY = 4096
  - dma_burst_t enum {FIXED, INCR} (reuse axi_pkg burst encoding if present)
  - error source codes DMA_ERR_SRC_STREAM_RD / DMA_ERR_SRC_STREAM_WR
- Sub-module dma_burst_calc: purely combinational (addr, bytes_rem, mode -> beats, alen, size, burst). It is reused later by the AXI I/F data-beat counter.

Test Plan (DATA_WIDTH=32, BPB=4):
1. Read, src=0x1000, num_bytes=64, ready=1 -> one request addr=0x1000, alen=15, size=2, INCR. Done pulses the cycle after the handshake; err never valid.
2. Read, src=0x0FF0, num_bytes=64 -> req1 addr=0x0FF0 alen=3, then req2 addr=0x1000 alen=11, then done.
3. Write, dst=0x0, num_bytes=2048 -> req addr=0x000 alen=255, then req addr=0x400 alen=255, then done. Exactly 2 handshakes.
4. Read, src=0x1002, num_bytes=16 -> err.valid=1 for 1 cycle with src=STREAM_RD, addr=0x1002. Done the next cycle; req_valid never asserted.
5. Backpressure/abort, src=0x2000, num_bytes=32, ready=0 for 5 cycles -> request fields stable across all 5 cycles. Then drop stream_valid while still waiting; raise ready -> one handshake, return to IDLE, no done.
6. num_bytes=0 -> done the cycle after valid with no request. Separately, rstn low mid-ST_REQ -> req_valid=0 immediately, with no clock edge required.
